grf_wb_port: RTL
================

// Module: grf_wb_port
// PURPOSE
// - General register file that terminates the MEM->WB pipeline. It consumes the WB-stage
//   write bundle (PC, instr, A3, WD) latched by the pipeline register ahead of it.
// - Serves two combinational read ports to the ID stage.
// - Internal write-to-read bypass: a value written in WB is visible in ID in the same cycle.
// - Exposes a per-write trace bundle and a write counter for the testbench/commit checker.
// PARAMETERS
// - DATA_W   32  register and data width
// - ADDR_W   5   register index width (2**ADDR_W registers, index 0 hardwired to zero)
// - CNT_W    32  width of the retired-write counter
// PORTS
// - clk          in   1       single clock; all state updates on posedge
// - reset        in   1       synchronous, active-high
// - WB_PC        in   32      PC of the instruction in WB
// - WB_instr     in   32      instruction word in WB (trace only, not decoded)
// - WB_A3        in   ADDR_W  destination register index
// - WB_WD        in   DATA_W  write data
// - WB_we        in   1       write enable from WB control
// - ID_A1        in   ADDR_W  read port 1 index
// - ID_A2        in   ADDR_W  read port 2 index
// - ID_RD1       out  DATA_W  read port 1 data (combinational)
// - ID_RD2       out  DATA_W  read port 2 data (combinational)
// - trace_we     out  1       registered: a non-zero-index write committed last cycle
// - trace_pc     out  32      registered PC of that write
// - trace_addr   out  ADDR_W  registered index of that write
// - trace_data   out  DATA_W  registered data of that write
// - wr_count     out  CNT_W   count of committed writes since reset
// BEHAVIOUR
// - Commit condition (eff_we) = WB_we && (WB_A3 != 0), evaluated on posedge clk.
// - On eff_we: reg[WB_A3] <= WB_WD. Otherwise the array holds.
// - Register 0 has no storage. It always reads 0, and writes to it are dropped.
//   They do not assert trace_we and do not increment wr_count.
// - Reads are combinational with same-cycle bypass:
//   - RDn = 0 if An == 0;
//   - else WB_WD if eff_we && An == WB_A3;
//   - else reg[An].
// - A1 == A2 == WB_A3 must forward WB_WD to both ports.
// - Trace regs load every cycle:
//   - trace_we <= eff_we.
//   - pc/addr/data load only when eff_we; otherwise they hold their last value.
// - wr_count increments by 1 on each eff_we and wraps modulo 2**CNT_W without a flag.
// - Reset (synchronous, priority over write):
//   - all registers, trace_*, and wr_count go to 0 on the posedge where reset == 1.
//   - A write presented in the same cycle as reset is lost.
//   - During reset, read ports still bypass WB_WD combinationally. ID is flushed by the
//     pipeline, so this is harmless.
// - Latency:
//   - write to array: 1 cycle.
//   - write to read: 0 cycles via bypass.
//   - write to trace: 1 cycle.
// - X-safety: WB_we == 0 with X on WB_A3/WB_WD must not disturb state or outputs.
// STRUCTURE
// - Shared package/header: DATA_W, ADDR_W, REG_ZERO = 0.
// - Array: reg [DATA_W-1:0] rf [1:2**ADDR_W-1] plus one always block for array, trace,
//   and counter.
// - One natural sub-module: grf_read_bypass, instanced twice. It performs the zero check,
//   the bypass compare, and the array mux.
// TESTING
// - Reset, then read all 32 indices -> RD1/RD2 = 0.
//   trace_we = 0, wr_count = 0.
// - WB_we=1, A3=5, WD=0x12345678, PC=0x3000; A1=5 the same cycle:
//   - RD1 = 0x12345678 via bypass.
//   - Next cycle (we=0): RD1 = 0x12345678 from the array.
//   - trace_we=1, trace_pc=0x3000, trace_addr=5, wr_count=1.
// - WB_we=1, A3=0, WD=0xFFFFFFFF; A1=0 ->
//   - RD1 = 0 that cycle and next.
//   - trace_we = 0, wr_count unchanged.
// - Back-to-back writes to A3=7 with 0xA then 0xB, A1=A2=7 both cycles ->
//   - RD1 = RD2 = 0xA in cycle 1, 0xB in cycle 2.
//   - wr_count += 2.
// - reset=1 together with WB_we=1, A3=3, WD=0x55 ->
//   - next cycle RD(3) = 0, trace_we = 0, wr_count = 0.
// - Preload wr_count to 0xFFFFFFFF via force, then one eff_we -> wr_count = 0.

Source files
------------

// File: rtl/grf_wb_port_pkg.sv
// Shared widths, the zero-register index and the trace record for the
// WB-stage general register file.
package grf_wb_port_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 32;
  localparam int PC_W     = 32;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // One committed write as seen by the commit checker.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } trace_t;

  // A write only takes effect when enabled and aimed at a real register.
  function automatic logic isCommit(input logic we, input logic [ADDR_W-1:0] a3);
    return we && (a3 != REG_ZERO);
  endfunction

endpackage

// File: rtl/grf_wb_port_if.sv
// Bus bundle between the WB/ID pipeline stages and the register file.
// The master side drives the write bundle and read indices; the slave side
// (the register file) returns read data, the trace record and the counter.
interface grf_wb_port_if;
  import grf_wb_port_pkg::*;

  logic [PC_W-1:0]   WB_PC;
  logic [31:0]       WB_instr;
  logic [ADDR_W-1:0] WB_A3;
  logic [DATA_W-1:0] WB_WD;
  logic              WB_we;
  logic [ADDR_W-1:0] ID_A1;
  logic [ADDR_W-1:0] ID_A2;
  logic [DATA_W-1:0] ID_RD1;
  logic [DATA_W-1:0] ID_RD2;
  logic              trace_we;
  logic [PC_W-1:0]   trace_pc;
  logic [ADDR_W-1:0] trace_addr;
  logic [DATA_W-1:0] trace_data;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output WB_PC, WB_instr, WB_A3, WB_WD, WB_we, ID_A1, ID_A2,
    input  ID_RD1, ID_RD2, trace_we, trace_pc, trace_addr, trace_data, wr_count
  );

  modport slave (
    input  WB_PC, WB_instr, WB_A3, WB_WD, WB_we, ID_A1, ID_A2,
    output ID_RD1, ID_RD2, trace_we, trace_pc, trace_addr, trace_data, wr_count
  );

endinterface

// File: rtl/grf_read_bypass.sv
// One combinational read port: register 0 reads as zero, a write committing
// this cycle to the same index is forwarded, otherwise the stored value.
module grf_read_bypass
  import grf_wb_port_pkg::*;
(
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] i_wbAddr,
  input  logic [DATA_W-1:0] i_wbData,
  input  logic              i_effWe,
  input  logic [DATA_W-1:0] i_rf [1:NUM_REGS-1],
  output logic [DATA_W-1:0] o_data
);

  // Zero check first, then same-cycle forward, then the array itself.
  always_comb begin
    o_data = '0;
    if (i_addr == REG_ZERO) begin
      o_data = '0;
    end else if (i_effWe && (i_addr == i_wbAddr)) begin
      o_data = i_wbData;
    end else begin
      o_data = i_rf[i_addr];
    end
  end

endmodule

// File: rtl/grf_wb_port.sv
// General register file terminating the MEM->WB pipeline: one write port fed
// by WB, two bypassed combinational read ports for ID, plus a registered trace
// of each committed write and a free-running committed-write counter.
module grf_wb_port
  import grf_wb_port_pkg::*;
(
  input logic           clk,
  input logic           reset,
  grf_wb_port_if.slave  bus
);

  logic [DATA_W-1:0] r_rf [1:NUM_REGS-1];
  logic              r_traceWe;
  trace_t            r_trace;
  logic [CNT_W-1:0]  r_wrCount;

  logic              w_effWe;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic              w_unusedInstr;

  assign w_effWe = isCommit(bus.WB_we, bus.WB_A3);

  // The instruction word travels with the bundle but is never decoded here.
  assign w_unusedInstr = ^bus.WB_instr;

  grf_read_bypass u_read1 (
    .i_addr   (bus.ID_A1),
    .i_wbAddr (bus.WB_A3),
    .i_wbData (bus.WB_WD),
    .i_effWe  (w_effWe),
    .i_rf     (r_rf),
    .o_data   (w_rd1)
  );

  grf_read_bypass u_read2 (
    .i_addr   (bus.ID_A2),
    .i_wbAddr (bus.WB_A3),
    .i_wbData (bus.WB_WD),
    .i_effWe  (w_effWe),
    .i_rf     (r_rf),
    .o_data   (w_rd2)
  );

  // Array, trace and counter share one clocked block; reset beats a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        r_rf[i] <= '0;
      end
      r_traceWe <= 1'b0;
      r_trace   <= '0;
      r_wrCount <= '0;
    end else begin
      r_traceWe <= w_effWe;
      if (w_effWe) begin
        r_rf[bus.WB_A3] <= bus.WB_WD;
        r_trace.pc      <= bus.WB_PC;
        r_trace.addr    <= bus.WB_A3;
        r_trace.data    <= bus.WB_WD;
        r_wrCount       <= r_wrCount + 1'b1;
      end
    end
  end

  assign bus.ID_RD1     = w_rd1;
  assign bus.ID_RD2     = w_rd2;
  assign bus.trace_we   = r_traceWe;
  assign bus.trace_pc   = r_trace.pc;
  assign bus.trace_addr = r_trace.addr;
  assign bus.trace_data = r_trace.data;
  assign bus.wr_count   = r_wrCount;

endmodule
